// File: rtl/sha256_w_schedule_streamer.sv
// SHA-256 message schedule streamer: loads one 512-bit block and emits W0..W63
// one word per accepted handshake, computing W16..W63 on the fly from a 16-word window.
module sha256_w_schedule_streamer (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_in,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         w_last,
  output logic         busy,
  output logic         fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and w_out comes straight from registers.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] win [16];
  logic [5:0]  idx;
  logic        accept;
  logic        advance;
  logic        last_hs;
  logic [31:0] wnew;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    sig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Window slot 0 holds W[t-16] for the word being appended, slot 15 holds W[t-1].
  assign wnew = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    w_valid   = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    last_hs   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        if (w_ready) begin
          if (idx == 6'd63) begin
            last_hs   = 1'b1;
            state_nxt = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign w_out     = win[0];
  assign w_idx     = idx;
  assign w_last    = w_valid && (idx == 6'd63);
  assign fsm_state = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      idx   <= 6'd0;
      for (int i = 0; i < 16; i++) win[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx <= 6'd0;
        for (int i = 0; i < 16; i++) win[i] <= block_in[511-32*i -: 32];
      end else if (advance) begin
        // The final handshake leaves the window and index alone; the next block reloads both.
        idx <= idx + 6'd1;
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= wnew;
      end
    end
  end

  logic unused_last_hs;
  assign unused_last_hs = last_hs;

endmodule

// File: doc/sha256_w_schedule_streamer.md
SHA256_W_SCHEDULE_STREAMER -- requirements
Module: sha256_w_schedule_streamer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-002 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: block_in holds a message block to load.
REQ-004 SHALL have port in_ready, output, 1 bit: the block accepts a message block this cycle.
REQ-005 SHALL have port block_in, input, 512 bits: message block, with W0 = [511:480] and W15 = [31:0].
REQ-006 SHALL have port w_valid, output, 1 bit: w_out holds a valid schedule word.
REQ-007 SHALL have port w_ready, input, 1 bit: the consumer accepts w_out this cycle.
REQ-008 SHALL have port w_out, output, 32 bits: schedule word W[w_idx].
REQ-009 SHALL have port w_idx, output, 6 bits: index t (0..63) of w_out.
REQ-010 SHALL have port w_last, output, 1 bit: high when w_valid=1 and w_idx=63.
REQ-011 SHALL have port busy, output, 1 bit: high while a block is being streamed.

Function
REQ-012 SHALL implement a two-state FSM with states IDLE and RUN.
REQ-013 SHALL drive in_ready=1 only in IDLE and in_ready=0 in RUN.
REQ-014 SHALL accept a block when in_valid & in_ready: load a 16x32 window register with W0..W15, set the index counter to 0, and move to RUN.
REQ-015 SHALL drive w_valid=1 and busy=1 throughout RUN, and w_valid=0 and busy=0 in IDLE.
REQ-016 SHALL present the first word W0 on w_out in the cycle after acceptance (latency 1 cycle).
REQ-017 SHALL drive w_out from the oldest window entry, directly from registers, with no combinational path from w_ready to w_out.
REQ-018 SHALL, on a handshake (w_valid & w_ready), shift the window by one, append the new word Wnew, and increment the index.
REQ-019 SHALL compute Wnew = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^32, where t is the index of the appended word.
- s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
- s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-020 SHALL hold w_out, w_idx and the window unchanged in any RUN cycle with w_ready=0, for any number of stall cycles.
REQ-021 SHALL, on the handshake with w_idx=63, return to IDLE; in_ready rises the next cycle, giving exactly one bubble cycle between blocks.
REQ-022 SHALL ignore in_valid in RUN; a block presented then is not consumed.
REQ-023 SHALL ignore the content of the appended word after index 63; the counter does not wrap within a block.
REQ-024 SHALL treat block_in as don't-care when in_valid=0, and SHALL sample block_in only at the acceptance edge.

Reset
REQ-025 SHALL, on RST=1 at any time (including mid-stream), force IDLE asynchronously.
REQ-026 SHALL reset outputs as follows: in_ready=1, w_valid=0, w_last=0, busy=0, w_idx=0, w_out=0.
REQ-027 SHALL clear the window register to zero on reset.
REQ-028 SHALL discard a block that was in progress at reset; after reset is released, no further words of that block are emitted.
REQ-029 SHALL accept a new block in the first clock edge after RST deasserts, provided in_valid=1.

Verification
REQ-030 SHALL pass an "abc" padded block test with w_ready tied to 1.
- Stimulus: block_in = 0x61626380, then 14 zero words, then 0x00000018.
- Required: W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
- Required: 64 words in 64 consecutive cycles; w_last only with w_idx=63.
REQ-031 SHALL pass an all-zero block test.
- Stimulus: block_in = 0.
- Required: all 64 words = 0x00000000, and busy is high for exactly 64 cycles with no stalls.
REQ-032 SHALL pass a random backpressure test.
- Stimulus: the "abc" block with w_ready randomly toggled.
- Required: the word sequence is identical to REQ-030, w_out/w_idx are stable during every stall, and no word is duplicated or skipped.
REQ-033 SHALL pass a back-to-back blocks test.
- Stimulus: in_valid held high with two blocks.
- Required: the second block is accepted exactly one cycle after the w_last handshake, and in_ready=0 for the whole first stream.
REQ-034 SHALL pass a mid-stream reset test.
- Stimulus: RST pulsed at w_idx=20.
- Required: outputs show reset values immediately without waiting for a clock edge, and the next accepted block restarts at w_idx=0 with correct W0.
REQ-035 SHALL pass an in_valid-during-RUN test.
- Stimulus: a second block presented while streaming.
- Required: it is not accepted until IDLE, and the streamed words of the first block are unaffected.
